// File: rtl/otp_stream_decryptor.sv
// otp_stream_decryptor: receive side of the one-time-pad link.
// Ports: clk/rst (sync, active-high), in_* ciphertext handshake,
//   out_* plaintext handshake, resync pulse, sync_err, err_count.
module otp_stream_decryptor #(
   parameter logic [31:0] SEED  = 32'hBDCA2C92,
   parameter int          ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [2:0]       in_index,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [2:0]       out_index,
   input  logic             resync,
   output logic             sync_err,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic {
      ST_RUN,
      ST_HUNT
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_lfsr;
   logic [2:0]       r_exp_idx;
   logic             r_out_valid;
   logic [7:0]       r_out_data;
   logic [2:0]       r_out_index;
   logic             r_sync_err;
   logic [ERR_W-1:0] r_err_count;

   logic [31:0]      w_lfsr_nxt;
   logic [7:0]       w_pad;
   logic             w_ready;
   logic             w_accept;
   logic             w_drain;
   logic             w_load;
   logic             w_mismatch;
   logic             w_err_sat;

   // Feedback must match the transmit-side generator exactly.
   assign w_lfsr_nxt = {r_lfsr[30:0],
                        ~(r_lfsr[31] ^ r_lfsr[21] ^
                          r_lfsr[1]  ^ r_lfsr[0])};

   // Pad taps from the pre-step register; pad[0] is bit 23.
   assign w_pad = {r_lfsr[2],  r_lfsr[3],  r_lfsr[5],
                   r_lfsr[7],  r_lfsr[11], r_lfsr[13],
                   r_lfsr[17], r_lfsr[23]};

   // HUNT always sinks traffic; RUN is gated by the
   // one-entry output register. resync blocks acceptance.
   assign w_ready = ~rst & ~resync &
                    ((r_state == ST_HUNT) |
                     ~r_out_valid | out_ready);

   assign w_accept  = in_valid & w_ready;
   assign w_drain   = r_out_valid & out_ready;
   assign w_err_sat = &r_err_count;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_mismatch  = 1'b0;
      if (resync) begin
         w_state_nxt = ST_RUN;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (w_accept) begin
                  if (in_index == r_exp_idx) begin
                     w_load = 1'b1;
                  end else begin
                     w_mismatch  = 1'b1;
                     w_state_nxt = ST_HUNT;
                  end
               end
            end
            ST_HUNT: begin
               w_state_nxt = ST_HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Pad generator and slot tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr    <= SEED;
         r_exp_idx <= 3'd0;
      end else if (resync) begin
         r_lfsr    <= SEED;
         r_exp_idx <= 3'd0;
      end else if (w_load) begin
         r_lfsr    <= w_lfsr_nxt;
         r_exp_idx <= r_exp_idx + 3'd1;
      end
   end

   // One-entry output register; a load wins over a drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_index <= 3'h0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= in_data ^ w_pad;
         r_out_index <= in_index;
      end else if (w_drain) begin
         r_out_valid <= 1'b0;
      end
   end

   // Sticky error flag and saturating event counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_err  <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (resync) begin
            r_sync_err <= 1'b0;
         end else if (w_mismatch) begin
            r_sync_err <= 1'b1;
         end
         if (w_mismatch && !w_err_sat) begin
            r_err_count <= r_err_count +
                           {{(ERR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign in_ready  = w_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_index = r_out_index;
   assign sync_err  = r_sync_err;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_otp_stream_decryptor.sv
// tb_otp_stream_decryptor: directed and random stimulus
// against a behavioural model of the decryptor.
module tb_otp_stream_decryptor;

   localparam logic [31:0] SEED = 32'hBDCA2C92;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_index;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_index;
   logic       resync;
   logic       sync_err;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   otp_stream_decryptor #(.SEED(SEED), .ERR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_index  (in_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .resync    (resync),
      .sync_err  (sync_err),
      .err_count (err_count)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_lfsr = SEED;
   int          m_exp  = 0;
   bit          m_hunt = 0;
   bit          m_serr = 0;
   int          m_ecnt = 0;
   bit          m_ov   = 0;
   logic [7:0]  m_od   = 8'h00;
   logic [2:0]  m_oi   = 3'h0;
   bit          last_acc;
   bit          tgl = 0;

   function automatic logic [7:0] pad_of(logic [31:0] x);
      int tap [8] = '{23, 17, 13, 11, 7, 5, 3, 2};
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) p[i] = x[tap[i]];
      return p;
   endfunction

   function automatic logic [31:0] step_of(logic [31:0] x);
      logic [31:0] fb;
      fb = (((x >> 31) ^ (x >> 21) ^ (x >> 1) ^ x) & 1) ^ 1;
      return (x << 1) | fb;
   endfunction

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      bit rdy, acc, drn;
      @(negedge clk);
      rdy = !rst && !resync && (m_hunt || !m_ov || out_ready);
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      acc = in_valid && rdy;
      drn = m_ov && out_ready;
      @(posedge clk);
      if (rst) begin
         m_lfsr = SEED; m_exp = 0; m_hunt = 0;
         m_serr = 0; m_ecnt = 0;
         m_ov = 0; m_od = 8'h00; m_oi = 3'h0;
         acc = 0;
      end else begin
         bit ld = 0;
         if (resync) begin
            m_lfsr = SEED; m_exp = 0; m_serr = 0; m_hunt = 0;
         end else if (acc && !m_hunt) begin
            if (int'(in_index) == m_exp) begin
               ld = 1;
               m_od = in_data ^ pad_of(m_lfsr);
               m_oi = in_index;
               m_lfsr = step_of(m_lfsr);
               m_exp = (m_exp + 1) % 8;
            end else begin
               m_serr = 1;
               m_hunt = 1;
               if (m_ecnt < 255) m_ecnt++;
            end
         end
         if (ld) m_ov = 1;
         else if (drn) m_ov = 0;
      end
      last_acc = acc;
      #1;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("out_data", {24'd0, out_data}, {24'd0, m_od});
      chk("out_index", {29'd0, out_index}, {29'd0, m_oi});
      chk("sync_err", {31'd0, sync_err}, {31'd0, m_serr});
      chk("err_count", {24'd0, err_count}, m_ecnt);
      if (tgl) out_ready = !out_ready;
   endtask

   task automatic send(input logic [7:0] d, input logic [2:0] idx);
      in_valid = 1'b1;
      in_data  = d;
      in_index = idx;
      for (int k = 0; k < 8; k++) begin
         step();
         if (last_acc) break;
      end
      chk("accept_bound", {31'd0, last_acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic pulse_resync();
      resync = 1'b1;
      step();
      resync = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      in_index = 3'h0; out_ready = 1'b1; resync = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);

      // first two pads of SEED are 1F then A9
      send(8'h5E, 3'd0);
      chk("t1_d0", {24'd0, out_data}, 32'h41);
      send(8'hA9, 3'd1);
      chk("t1_d1", {24'd0, out_data}, 32'h00);
      chk("t1_idx1", {29'd0, out_index}, 32'd1);
      step();

      // ordered stream with stalling consumer
      pulse_resync();
      tgl = 1;
      for (int i = 0; i < 10; i++) send($urandom, 3'(i % 8));
      for (int i = 0; i < 3; i++) step();
      tgl = 0;
      out_ready = 1'b1;
      step();
      chk("t2_err0", {24'd0, err_count}, 32'd0);

      // mismatch drops into HUNT
      pulse_resync();
      send($urandom, 3'd0);
      send($urandom, 3'd1);
      step();
      send($urandom, 3'd5);
      chk("t3_serr", {31'd0, sync_err}, 32'd1);
      chk("t3_ecnt", {24'd0, err_count}, 32'd1);
      for (int i = 0; i < 3; i++) send($urandom, 3'($urandom));
      chk("t3_ecnt_hold", {24'd0, err_count}, 32'd1);
      chk("t3_no_out", {31'd0, out_valid}, 32'd0);

      // resync beats a same-cycle byte
      in_valid = 1'b1; in_data = 8'h77; in_index = 3'd0;
      pulse_resync();
      in_valid = 1'b0;
      chk("t4_serr_clr", {31'd0, sync_err}, 32'd0);
      send(8'h5E, 3'd0);
      chk("t4_d", {24'd0, out_data}, 32'h41);
      chk("t4_ecnt", {24'd0, err_count}, 32'd1);

      // saturation
      for (int i = 0; i < 300; i++) begin
         pulse_resync();
         send($urandom, 3'd5);
      end
      chk("t5_sat", {24'd0, err_count}, 32'hFF);

      // reset while a byte is held
      pulse_resync();
      out_ready = 1'b0;
      send($urandom, 3'd0);
      chk("t6_held", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_ov", {31'd0, out_valid}, 32'd0);
      chk("t6_od", {24'd0, out_data}, 32'd0);
      out_ready = 1'b1;
      d = 8'($urandom);
      send(d, 3'd0);
      chk("t6_pad", {24'd0, out_data ^ d}, 32'h1F);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = 8'($urandom);
         in_index  = (($urandom % 12) == 0) ?
                     3'($urandom) : 3'(m_exp);
         out_ready = ($urandom % 3) != 0;
         resync    = ($urandom % 25) == 0;
         rst       = ($urandom % 150) == 0;
         step();
      end
      rst = 1'b0; resync = 1'b0; in_valid = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
